cmd_dispatch: RTL and testbench
===============================

Name: cmd_dispatch

Overview:
Parametrised command dispatcher between the packet FIFO (first-word-fall-through) and the command units (clear, load_vertex, load_edge, draw_tri, swap, status). It replaces the fixed per-opcode hold wires with a table-driven issue stage. The issue stage adds per-channel busy gating, a vsync-released lock channel, barrier channels that wait for the whole pipeline to drain, invalid-opcode dropping and a hold watchdog. It emits one-cycle command pulses plus a registered copy of the issued packet, so downstream units no longer read live FIFO data.

Parameters:
SIZE, 256, packet size in bytes; packet bus is 8*SIZE bits
NCH, 8, number of command channels; opcode k (1..NCH) maps to channel k-1
OPCODE_BYTE, 2, byte index of the opcode within the packet
LEN_BYTE, 1, byte index of the length field
LOCK_IDX, 0, channel whose issue sets the vsync lock
LOCK_MASK, 8'b0000_0011, channels held while the lock is set
BARRIER_MASK, 8'b0000_0001, channels issued only when every busy_in bit and the lock are 0
TIMEOUT, 1048576, consecutive held cycles before err_timeout is set

Ports:
CLK  in  1  system clock
rst  in  1  synchronous, active-high reset
fifo_empty  in  1  packet FIFO empty
fifo_data  in  8*SIZE  FIFO head packet, valid while !fifo_empty
rd_en  out  1  FIFO pop, one-cycle pulse
busy_in  in  NCH  per-channel busy from the command units
vsync  in  1  VGA VS, active low; falling edge releases the lock
cmd_pulse  out  NCH  one-hot, one-cycle issue strobe
cmd_packet  out  8*SIZE  last issued packet, held until the next issue
cmd_len  out  8  length byte of the last issued packet
busy_out  out  NCH  busy_in OR (lock at LOCK_IDX); feeds cmd_status
err_opcode  out  1  sticky: invalid opcode dropped
err_timeout  out  1  sticky: head held for TIMEOUT cycles
drop_count  out  16  number of dropped packets, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0, state IDLE, lock 0, watchdog 0. rst overrides every state in the same cycle, and no cmd_pulse is emitted on the cycle after reset.
- Decode, combinational on the head: op = fifo_data[8*OPCODE_BYTE +: 8]; ch = op-1; valid = (op >= 1) && (op <= NCH).
- Hold condition for a valid head: busy_in[ch] | (LOCK_MASK[ch] & lock) | (BARRIER_MASK[ch] & (|busy_in | lock)).
- FSM IDLE:
  - fifo_empty: stay in IDLE.
  - Invalid head: rd_en=1, err_opcode<=1, drop_count increments (saturating), next state GAP.
  - Valid head, not held: rd_en=1, cmd_packet<=fifo_data, cmd_len<=fifo_data[8*LEN_BYTE +: 8], latch ch, next state ISSUE.
  - Valid head, held: stay in IDLE, rd_en=0.
- FSM ISSUE: cmd_pulse[ch]=1 for exactly one cycle; next state GAP.
- FSM GAP: one dead cycle so the FIFO head and empty flag update; next state IDLE.
- Latency: head visible -> rd_en in the same cycle -> cmd_pulse one cycle later. Peak throughput is one packet per 3 cycles; a dropped packet costs 2 cycles.
- Lock:
  - Set on the cycle cmd_pulse[LOCK_IDX] is high.
  - Cleared when vs_fall = vs_d & ~vsync and lock is set.
  - If set and vs_fall coincide, set wins and lock stays 1.
  - While locked, a head on a LOCK_MASK channel is held, not dropped.
- Busy sampling: busy_in is sampled in IDLE only. A unit must raise busy no later than one cycle after its cmd_pulse. The GAP cycle guarantees this is seen before the next same-channel evaluation.
- Watchdog:
  - Counter increments each IDLE cycle with a valid held head.
  - Clears on issue, drop, or fifo_empty.
  - When it reaches TIMEOUT-1, err_timeout<=1 (sticky). The counter saturates and the packet is not dropped.
- Widths: watchdog is $clog2(TIMEOUT+1) bits. NCH must be <= 255. Parameter masks are NCH bits wide; extra bits are ignored.

Test Plan:
- Head op=0x03, len=0x10, busy_in=0 -> rd_en high 1 cycle; next cycle cmd_pulse=8'h04 for 1 cycle; cmd_packet equals the head; cmd_len=0x10; next rd_en no earlier than 3 cycles after the first.
- Issue op=0x01, then queue op=0x02 -> lock=1 and busy_out=8'h01. 0x02 is held with no rd_en until vsync falls; rd_en in the cycle after vs_d updates, cmd_pulse=8'h02 one cycle later; lock=0.
- Head op=0x05 with busy_in[4]=1 for 50 cycles -> no rd_en for 50 cycles; issue within 1 cycle of busy_in[4] dropping.
- Heads op=0x00, then op=0x09 (NCH=8) -> both popped, no cmd_pulse, err_opcode=1, drop_count=2. A following 0x06 still issues with cmd_pulse=8'h20.
- Barrier: busy_in=8'h20, head op=0x01 -> held until busy_in=0, then cmd_pulse=8'h01. Swap lock-set coincident with a vsync fall -> lock stays 1.
- TIMEOUT=16, head 0x03 held with busy_in[2]=1 for 20 cycles -> err_timeout rises on the 16th held cycle and the packet stays in the FIFO. rst pulse -> all outputs 0.

Source files
------------

// File: rtl/cmd_dispatch.sv
// cmd_dispatch: table-driven issue stage between the packet FIFO (FWFT) and
// the command units. Pops one packet per issue, emits a one-hot command pulse
// and holds a registered copy of the issued packet for the downstream units.
//
// state | meaning
// IDLE  | evaluate FIFO head: drop, issue or hold
// ISSUE | cmd_pulse asserted for the latched channel
// GAP   | dead cycle so FIFO head/empty and unit busy flags settle
module cmd_dispatch #(
    parameter int              SIZE         = 256,
    parameter int              NCH          = 8,
    parameter int              OPCODE_BYTE  = 2,
    parameter int              LEN_BYTE     = 1,
    parameter int              LOCK_IDX     = 0,
    parameter logic [NCH-1:0]  LOCK_MASK    = NCH'(8'b0000_0011),
    parameter logic [NCH-1:0]  BARRIER_MASK = NCH'(8'b0000_0001),
    parameter int              TIMEOUT      = 1048576
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [8*SIZE-1:0]   fifo_data,
    output logic                rd_en,
    input  logic [NCH-1:0]      busy_in,
    input  logic                vsync,
    output logic [NCH-1:0]      cmd_pulse,
    output logic [8*SIZE-1:0]   cmd_packet,
    output logic [7:0]          cmd_len,
    output logic [NCH-1:0]      busy_out,
    output logic                err_opcode,
    output logic                err_timeout,
    output logic [15:0]         drop_count
);

    localparam int             CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     op;
    logic [7:0]     op_m1;
    logic [CHW-1:0] ch;
    logic           valid;
    logic           held;
    logic           lock;
    logic           vs_d;
    logic           vs_fall;
    logic [WDW-1:0] wd;
    logic           issue;
    logic           drop;
    logic           hold_cyc;

    // Head decode; ch is only meaningful when valid is set.
    assign op      = fifo_data[8*OPCODE_BYTE +: 8];
    assign op_m1   = op - 8'd1;
    assign ch      = op_m1[CHW-1:0];
    assign valid   = (op != 8'd0) && (op <= 8'(NCH));
    assign held    = busy_in[ch]
                   | (LOCK_MASK[ch] & lock)
                   | (BARRIER_MASK[ch] & ((|busy_in) | lock));
    assign vs_fall = vs_d & ~vsync;
    assign busy_out = busy_in | (NCH'(lock) << LOCK_IDX);

    // State register.
    always_ff @(posedge CLK) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and pop/issue/drop decisions; reset suppresses every strobe.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        issue     = 1'b0;
        drop      = 1'b0;
        hold_cyc  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!valid) begin
                        rd_en     = 1'b1;
                        drop      = 1'b1;
                        state_nxt = GAP;
                    end else if (!held) begin
                        rd_en     = 1'b1;
                        issue     = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        hold_cyc  = 1'b1;
                    end
                end
            end
            ISSUE:   state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            rd_en    = 1'b0;
            issue    = 1'b0;
            drop     = 1'b0;
            hold_cyc = 1'b0;
        end
    end

    // Issued packet capture and one-hot pulse (high exactly during ISSUE).
    always_ff @(posedge CLK) begin
        if (rst) begin
            cmd_pulse  <= '0;
            cmd_packet <= '0;
            cmd_len    <= '0;
        end else begin
            cmd_pulse <= '0;
            if (issue) begin
                cmd_pulse  <= NCH'(1) << ch;
                cmd_packet <= fifo_data;
                cmd_len    <= fifo_data[8*LEN_BYTE +: 8];
            end
        end
    end

    // Vsync-released lock; a new set beats a coincident vsync fall.
    always_ff @(posedge CLK) begin
        if (rst) begin
            lock <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            vs_d <= vsync;
            if (cmd_pulse[LOCK_IDX]) lock <= 1'b1;
            else if (vs_fall)        lock <= 1'b0;
        end
    end

    // Invalid-opcode bookkeeping: sticky flag and saturating drop counter.
    always_ff @(posedge CLK) begin
        if (rst) begin
            err_opcode <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            err_opcode <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    // Hold watchdog: counts held IDLE cycles, saturates and flags; never drops.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wd          <= '0;
            err_timeout <= 1'b0;
        end else if (issue || drop || (state == IDLE && fifo_empty)) begin
            wd <= '0;
        end else if (hold_cyc) begin
            if (wd == WD_LAST) err_timeout <= 1'b1;
            else               wd <= wd + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Bench for cmd_dispatch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a cycle-count based model.
module tb_cmd_dispatch;

    localparam int         SIZE = 4;
    localparam int         NCH  = 8;
    localparam int         TMO  = 16;
    localparam logic [7:0] LM   = 8'h03;
    localparam logic [7:0] BM   = 8'h01;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        rd_en;
    logic [7:0]  busy_in = '0;
    logic        vsync = 1'b1;
    logic [7:0]  cmd_pulse;
    logic [31:0] cmd_packet;
    logic [7:0]  cmd_len;
    logic [7:0]  busy_out;
    logic        err_opcode;
    logic        err_timeout;
    logic [15:0] drop_count;

    cmd_dispatch #(.SIZE(SIZE), .NCH(NCH), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .rd_en(rd_en), .busy_in(busy_in), .vsync(vsync), .cmd_pulse(cmd_pulse),
        .cmd_packet(cmd_packet), .cmd_len(cmd_len), .busy_out(busy_out),
        .err_opcode(err_opcode), .err_timeout(err_timeout), .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int          cyc = 0;

    // Model state
    int          ready_at = 0;
    bit          in_rst = 0;
    bit          m_lock = 0, m_vsd = 0, m_err_op = 0, m_err_to = 0;
    logic [7:0]  m_pulse = '0, m_len = '0;
    logic [31:0] m_pkt = '0;
    logic [15:0] m_drops = '0;
    int          m_wd = 0;

    // Samples taken at the falling edge of the last step
    logic        s_rd, s_err_op, s_err_to;
    logic [7:0]  s_pulse, s_len, s_busy_out;
    logic [31:0] s_pkt;
    logic [15:0] s_drops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v, input logic r);
        logic [31:0] head;
        logic [7:0]  op;
        int          chn;
        bit          empty, valid, held, can, exp_rd, next_lock;
        rst     = r;
        busy_in = b;
        vsync   = v;
        empty   = (q.size() == 0);
        head    = empty ? $urandom : q[0];
        fifo_empty = empty;
        fifo_data  = head;
        @(negedge CLK);
        s_rd = rd_en; s_pulse = cmd_pulse; s_pkt = cmd_packet; s_len = cmd_len;
        s_busy_out = busy_out; s_err_op = err_opcode; s_err_to = err_timeout;
        s_drops = drop_count;

        op    = head[23:16];
        chn   = int'(op) - 1;
        valid = !empty && op >= 8'd1 && op <= 8'(NCH);
        held  = valid && (b[chn] || (LM[chn] && m_lock) || (BM[chn] && (b != 0 || m_lock)));
        can   = !r && cyc >= ready_at && !empty;
        exp_rd = can && (!valid || !held);

        if (!r || in_rst) begin
            chk("rd_en", 32'(s_rd), 32'(exp_rd));
            chk("cmd_pulse", 32'(s_pulse), 32'(m_pulse));
            chk("cmd_packet", s_pkt, m_pkt);
            chk("cmd_len", 32'(s_len), 32'(m_len));
            chk("busy_out", 32'(s_busy_out), 32'(b | (8'(m_lock))));
            chk("err_opcode", 32'(s_err_op), 32'(m_err_op));
            chk("err_timeout", 32'(s_err_to), 32'(m_err_to));
            chk("drop_count", 32'(s_drops), 32'(m_drops));
        end

        if (r) begin
            in_rst = 1; m_lock = 0; m_vsd = 0; m_err_op = 0; m_err_to = 0;
            m_pulse = '0; m_len = '0; m_pkt = '0; m_drops = '0; m_wd = 0;
            ready_at = cyc + 1;
        end else begin
            in_rst = 0;
            next_lock = m_pulse[0] ? 1'b1 : ((m_vsd && !v) ? 1'b0 : m_lock);
            m_lock = next_lock;
            m_vsd  = v;
            m_pulse = '0;
            if (can && valid && !held) begin
                m_pkt = head; m_len = head[15:8]; m_pulse = 8'(1) << chn;
                ready_at = cyc + 3; m_wd = 0; void'(q.pop_front());
            end else if (can && !valid) begin
                m_err_op = 1;
                if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                ready_at = cyc + 2; m_wd = 0; void'(q.pop_front());
            end else if (can && held) begin
                if (m_wd == TMO - 1) m_err_to = 1;
                else m_wd++;
            end else if (cyc >= ready_at && empty) begin
                m_wd = 0;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rv;
        // Reset
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("lit_reset_rd", 32'(s_rd), 32'd0);
        chk("lit_reset_pulse", 32'(s_pulse), 32'd0);
        chk("lit_reset_drops", 32'(s_drops), 32'd0);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_post_reset_pulse", 32'(s_pulse), 32'd0);

        // Basic issue: op 3, len 0x10
        q.push_back(32'hA5_03_10_5A);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_basic_rd", 32'(s_rd), 32'd1);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_basic_pulse", 32'(s_pulse), 32'h04);
        chk("lit_basic_len", 32'(s_len), 32'h10);
        chk("lit_basic_pkt", s_pkt, 32'hA5_03_10_5A);
        step(8'h00, 1'b1, 1'b0);

        // Lock: op1 sets it, op2 held until vsync falls
        q.push_back(32'h00_01_22_00);
        q.push_back(32'h00_02_33_00);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_lock_rd1", 32'(s_rd), 32'd1);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_lock_pulse1", 32'(s_pulse), 32'h01);
        step(8'h00, 1'b1, 1'b0);
        chk("lit_lock_busy_out", 32'(s_busy_out), 32'h01);
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 1'b1, 1'b0);
            chk("lit_lock_held", 32'(s_rd), 32'd0);
        end
        step(8'h00, 1'b0, 1'b0);
        chk("lit_lock_fall_rd", 32'(s_rd), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_lock_release_rd", 32'(s_rd), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_lock_pulse2", 32'(s_pulse), 32'h02);
        chk("lit_lock_cleared", 32'(s_busy_out), 32'h00);
        step(8'h00, 1'b0, 1'b0);

        // Invalid opcodes 0 and 9, then 6 still issues
        q.push_back(32'h00_00_01_00);
        q.push_back(32'h00_09_01_00);
        q.push_back(32'h00_06_07_00);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_inv_pulse", 32'(s_pulse), 32'h20);
        chk("lit_inv_err", 32'(s_err_op), 32'd1);
        chk("lit_inv_drops", 32'(s_drops), 32'd2);
        step(8'h00, 1'b0, 1'b0);

        // Barrier on channel 0, lock set coincident with vsync fall
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        q.push_back(32'h00_01_44_00);
        for (int i = 0; i < 4; i++) begin
            step(8'h20, 1'b1, 1'b0);
            chk("lit_barrier_held", 32'(s_rd), 32'd0);
        end
        step(8'h00, 1'b1, 1'b0);
        chk("lit_barrier_rd", 32'(s_rd), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_barrier_pulse", 32'(s_pulse), 32'h01);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_coincident_lock", 32'(s_busy_out), 32'h01);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_lock_cleared2", 32'(s_busy_out), 32'h00);

        // Watchdog: op3 held by busy_in[2]
        q.push_back(32'h00_03_55_00);
        for (int i = 1; i <= 20; i++) begin
            step(8'h04, 1'b0, 1'b0);
            chk("lit_wd_held", 32'(s_rd), 32'd0);
            if (i == 16) chk("lit_wd_not_yet", 32'(s_err_to), 32'd0);
            if (i == 17) chk("lit_wd_flag", 32'(s_err_to), 32'd1);
        end
        step(8'h00, 1'b0, 1'b0);
        chk("lit_wd_release_rd", 32'(s_rd), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        chk("lit_wd_pulse", 32'(s_pulse), 32'h04);
        step(8'h00, 1'b0, 1'b0);

        // Random traffic
        rv = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (q.size() < 4 && $urandom_range(0, 2) == 0)
                q.push_back({8'($urandom), 8'($urandom_range(0, 10)), 8'($urandom), 8'($urandom)});
            if ($urandom_range(0, 19) == 0) rv = ~rv;
            rb = 8'($urandom) & 8'($urandom) & 8'($urandom);
            step(rb, rv, (n >= 1500 && n < 1502) ? 1'b1 : 1'b0);
        end

        // Final reset pulse
        step(8'h00, 1'b1, 1'b1);
        step(8'h00, 1'b1, 1'b1);
        chk("lit_final_rd", 32'(s_rd), 32'd0);
        chk("lit_final_pulse", 32'(s_pulse), 32'd0);
        chk("lit_final_pkt", s_pkt, 32'd0);
        chk("lit_final_len", 32'(s_len), 32'd0);
        chk("lit_final_busy_out", 32'(s_busy_out), 32'd0);
        chk("lit_final_err_op", 32'(s_err_op), 32'd0);
        chk("lit_final_err_to", 32'(s_err_to), 32'd0);
        chk("lit_final_drops", 32'(s_drops), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
